wb_soc_reg_slave: RTL and testbench

//  Wishbone classic slave register bank for a SoC master peripheral (e.g. video output).

---
 rtl/wb_soc_reg_slave_pkg.sv | 18 +
 rtl/wb_soc_reg_slave_if.sv | 24 ++
 rtl/wb_soc_reg_slave.sv | 101 ++++++++++
 tb/tb_wb_soc_reg_slave.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_soc_reg_slave_pkg.sv
// Register offsets and bit positions for the SoC peripheral register slave.
// Offsets are word indices, decoded from WB byte-address bits [4:2].
package wb_soc_reg_pkg;

  localparam logic [2:0] OFF_BASE   = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_IRQEN  = 3'd3;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int STATUS_PEND_BIT = 0;
  localparam int IRQEN_BIT       = 0;

  function automatic logic is_mapped(input logic [2:0] off);
    return off <= OFF_IRQEN;
  endfunction

endpackage

// File: rtl/wb_soc_reg_slave_if.sv
// Wishbone classic bus bundle between the system bus master and the register slave.
interface wb_soc_reg_slave_if;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] ADR_I;
  logic        ACK_O;
  logic        CYC_I;
  logic        ERR_O;
  logic        LOCK_I;
  logic        RTY_O;
  logic [3:0]  SEL_I;
  logic        STB_I;
  logic        WE_I;

  modport master (
    output DAT_I, ADR_I, CYC_I, LOCK_I, SEL_I, STB_I, WE_I,
    input  DAT_O, ACK_O, ERR_O, RTY_O
  );

  modport slave (
    input  DAT_I, ADR_I, CYC_I, LOCK_I, SEL_I, STB_I, WE_I,
    output DAT_O, ACK_O, ERR_O, RTY_O
  );
endinterface

// File: rtl/wb_soc_reg_slave.sv
// Wishbone register bank: frame-buffer BASE, run flag, edge-triggered IRQ with W1C status.
// Single-cycle registered ACK/ERR; the 1-cycle response pulse blocks back-to-back requests.
module wb_soc_reg_slave #(
  parameter logic [31:0] BASE_RST  = 32'h4100_0000,
  parameter logic        IRQEN_RST = 1'b1
) (
  input  logic               p_clk,
  input  logic               p_reset,
  input  logic               raise_irq,
  output logic               irq,
  output logic [31:0]        module_register,
  output logic               initialized,
  output logic               written,
  wb_soc_reg_slave_if.slave  p_wb
);
  import wb_soc_reg_pkg::*;

  logic        pending;
  logic        irq_en;
  logic        raise_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;
  logic [31:0] rd_mux;
  logic [2:0]  off;
  logic        req;
  logic        mapped;
  logic        wr;
  logic        w1c;
  logic        irq_event;
  logic        unused_ok;

  assign off       = p_wb.ADR_I[4:2];
  assign mapped    = is_mapped(off);
  assign req       = p_wb.CYC_I & p_wb.STB_I & ~ack_q & ~err_q;
  assign wr        = req & p_wb.WE_I & mapped;
  assign w1c       = wr & (off == OFF_STATUS) & p_wb.SEL_I[0] & p_wb.DAT_I[STATUS_PEND_BIT];
  assign irq_event = raise_irq & ~raise_q;

  assign p_wb.ACK_O = ack_q;
  assign p_wb.ERR_O = err_q;
  assign p_wb.DAT_O = dat_q;
  assign p_wb.RTY_O = 1'b0;

  assign unused_ok = ^{p_wb.LOCK_I, p_wb.ADR_I[31:5], p_wb.ADR_I[1:0]};

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_BASE:   rd_mux = module_register;
      OFF_CTRL:   rd_mux[CTRL_RUN_BIT] = written;
      OFF_STATUS: rd_mux[STATUS_PEND_BIT] = pending;
      OFF_IRQEN:  rd_mux[IRQEN_BIT] = irq_en;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      module_register <= BASE_RST;
      initialized     <= 1'b0;
      written         <= 1'b0;
      pending         <= 1'b0;
      irq_en          <= IRQEN_RST;
      raise_q         <= 1'b0;
      irq             <= 1'b0;
      ack_q           <= 1'b0;
      err_q           <= 1'b0;
      dat_q           <= '0;
    end else begin
      ack_q   <= req & mapped;
      err_q   <= req & ~mapped;
      dat_q   <= (req & mapped) ? rd_mux : 32'h0;
      raise_q <= raise_irq;
      irq     <= pending & irq_en;

      // A new peripheral event outranks a simultaneous software clear.
      if (irq_event)
        pending <= 1'b1;
      else if (w1c)
        pending <= 1'b0;

      if (wr) begin
        case (off)
          OFF_BASE: begin
            for (int b = 0; b < 4; b++)
              if (p_wb.SEL_I[b])
                module_register[8*b +: 8] <= p_wb.DAT_I[8*b +: 8];
            initialized <= 1'b1;
          end
          OFF_CTRL:
            if (p_wb.SEL_I[0]) written <= p_wb.DAT_I[CTRL_RUN_BIT];
          OFF_IRQEN:
            if (p_wb.SEL_I[0]) irq_en <= p_wb.DAT_I[IRQEN_BIT];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Directed bench for wb_soc_reg_slave with a queue-based response scoreboard.
module tb_wb_soc_reg_slave;

  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        raise_irq = 1'b0;
  logic        irq;
  logic [31:0] module_register;
  logic        initialized;
  logic        written;

  wb_soc_reg_slave_if bus ();

  wb_soc_reg_slave dut (
    .p_clk           (p_clk),
    .p_reset         (p_reset),
    .raise_irq       (raise_irq),
    .irq             (irq),
    .module_register (module_register),
    .initialized     (initialized),
    .written         (written),
    .p_wb            (bus)
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge p_clk) begin
    if (!p_reset && (bus.ACK_O === 1'b1 || bus.ERR_O === 1'b1)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_response: ack=%b err=%b with nothing outstanding", bus.ACK_O, bus.ERR_O);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.ERR_O !== e.err || bus.ACK_O !== ~e.err || (e.chk && bus.DAT_O !== e.dat)) begin
          n_err++;
          $display("FAIL %s: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                   nm, bus.ACK_O, bus.ERR_O, bus.DAT_O, ~e.err, e.err, e.dat);
        end
      end
    end
  end

  // Entered and left at posedge+1; response must arrive after exactly one edge.
  task automatic wb_acc(input string nm, input logic [31:0] adr, input logic we,
                        input logic [31:0] d, input logic [3:0] sel,
                        input logic exp_err, input logic chk, input logic [31:0] exp_dat);
    exp_t e;
    int   lat;
    bit   got;
    e.err = exp_err; e.chk = chk; e.dat = exp_dat;
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.ADR_I = adr; bus.WE_I = we; bus.DAT_I = d; bus.SEL_I = sel;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 4) begin
      @(posedge p_clk); #1;
      lat++;
      if (bus.ACK_O === 1'b1 || bus.ERR_O === 1'b1) got = 1;
    end
    check({nm, "_latency"}, lat, 1);
    if (!got) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    @(posedge p_clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge p_clk); #1; end
  endtask

  initial begin
    bus.DAT_I = '0; bus.ADR_I = '0; bus.CYC_I = 0; bus.LOCK_I = 0;
    bus.SEL_I = '0; bus.STB_I = 0; bus.WE_I = 0;
    cycles(3);
    check("rst_module_register", module_register, 32'h4100_0000);
    check("rst_initialized", initialized, 0);
    check("rst_written", written, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", bus.ACK_O, 0);
    check("rst_err", bus.ERR_O, 0);
    check("rst_rty", bus.RTY_O, 0);
    check("rst_dat_o", bus.DAT_O, 0);
    p_reset = 1'b0;
    cycles(1);

    wb_acc("rd_irqen_rst", 32'h0C, 0, 0, 4'hF, 0, 1, 32'h1);

    wb_acc("wr_base", 32'h00, 1, 32'h4200_0000, 4'hF, 0, 0, 0);
    check("base_after_wr", module_register, 32'h4200_0000);
    check("init_after_wr", initialized, 1);
    wb_acc("wr_ctrl_run", 32'h04, 1, 32'h1, 4'hF, 0, 0, 0);
    check("written_set", written, 1);
    wb_acc("rd_ctrl", 32'h04, 0, 0, 4'hF, 0, 1, 32'h1);

    wb_acc("wr_base_byte0", 32'h00, 1, 32'h0000_00AA, 4'b0001, 0, 0, 0);
    check("base_byte0", module_register, 32'h4200_00AA);
    wb_acc("rd_base_byte0", 32'h00, 0, 0, 4'hF, 0, 1, 32'h4200_00AA);

    // raise_irq held high 4 cycles
    raise_irq = 1'b1;
    cycles(4);
    check("irq_after_raise", irq, 1);
    raise_irq = 1'b0;
    wb_acc("rd_status_pend", 32'h08, 0, 0, 4'hF, 0, 1, 32'h1);
    wb_acc("w1c_status", 32'h08, 1, 32'h1, 4'hF, 0, 0, 0);
    cycles(1);
    check("irq_after_w1c", irq, 0);
    wb_acc("rd_status_clr", 32'h08, 0, 0, 4'hF, 0, 1, 32'h0);

    // new edge coincides with W1C sampling edge
    raise_irq = 1'b1;
    cycles(2);
    raise_irq = 1'b0;
    cycles(1);
    raise_irq = 1'b1;
    wb_acc("w1c_vs_edge", 32'h08, 1, 32'h1, 4'hF, 0, 0, 0);
    cycles(1);
    check("irq_set_wins", irq, 1);
    wb_acc("rd_status_set_wins", 32'h08, 0, 0, 4'hF, 0, 1, 32'h1);
    // raise_irq still held: no further event after clearing
    wb_acc("w1c_held", 32'h08, 1, 32'h1, 4'hF, 0, 0, 0);
    cycles(2);
    check("irq_held_once", irq, 0);
    wb_acc("rd_status_held", 32'h08, 0, 0, 4'hF, 0, 1, 32'h0);
    raise_irq = 1'b0;
    cycles(1);

    wb_acc("wr_irqen_off", 32'h0C, 1, 32'h0, 4'hF, 0, 0, 0);
    raise_irq = 1'b1;
    cycles(2);
    raise_irq = 1'b0;
    cycles(2);
    check("irq_masked", irq, 0);
    wb_acc("rd_status_masked", 32'h08, 0, 0, 4'hF, 0, 1, 32'h1);
    wb_acc("rd_irqen_off", 32'h0C, 0, 0, 4'hF, 0, 1, 32'h0);
    wb_acc("w1c_masked", 32'h08, 1, 32'h1, 4'hF, 0, 0, 0);

    wb_acc("rd_unmapped_14", 32'h14, 0, 0, 4'hF, 1, 1, 32'h0);
    wb_acc("wr_unmapped_18", 32'h18, 1, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h0);
    wb_acc("rd_unmapped_1c", 32'h1C, 0, 0, 4'hF, 1, 1, 32'h0);
    wb_acc("rd_base_after_err", 32'h00, 0, 0, 4'hF, 0, 1, 32'h4200_00AA);

    wb_acc("wr_ctrl_stop", 32'h04, 1, 32'h0, 4'hF, 0, 0, 0);
    check("written_clr", written, 0);
    check("base_kept_on_stop", module_register, 32'h4200_00AA);
    wb_acc("wr_base_rearm", 32'h00, 1, 32'h4300_0000, 4'hF, 0, 0, 0);
    check("base_rewrite", module_register, 32'h4300_0000);

    // reset lands between request and its sampling edge
    bus.ADR_I = 32'h00; bus.WE_I = 1; bus.DAT_I = 32'hDEAD_BEEF; bus.SEL_I = 4'hF;
    bus.CYC_I = 1; bus.STB_I = 1;
    #2 p_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge p_clk); #1;
      check("abort_no_ack", {bus.ACK_O, bus.ERR_O}, 0);
    end
    check("abort_base_rst", module_register, 32'h4100_0000);
    check("abort_init_rst", initialized, 0);
    bus.CYC_I = 0; bus.STB_I = 0; bus.WE_I = 0;
    p_reset = 1'b0;
    cycles(1);
    wb_acc("rd_base_post_rst", 32'h00, 0, 0, 4'hF, 0, 1, 32'h4100_0000);
    wb_acc("rd_irqen_post_rst", 32'h0C, 0, 0, 4'hF, 0, 1, 32'h1);

    cycles(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
